// File: rtl/skiroc_scan_sequencer_pkg.sv
// rtl/skiroc_scan_sequencer_pkg.sv - shared types and constants for the SKIROC2 TA-scan sequencer
package skiroc_scan_sequencer_pkg;

    localparam int NUM_CHIPS = 4;

    localparam logic [NUM_CHIPS-1:0] CHIP1_SEL = 4'b1000;
    localparam logic [NUM_CHIPS-1:0] CHIP2_SEL = 4'b0100;
    localparam logic [NUM_CHIPS-1:0] CHIP3_SEL = 4'b0010;
    localparam logic [NUM_CHIPS-1:0] CHIP4_SEL = 4'b0001;

    localparam int TIMEOUT_CYC_DEFAULT = 10_000_000;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_END,
        GAP,
        DONE
    } scan_state_t;

endpackage

// File: rtl/skiroc_scan_sequencer_scan_next_chip.sv
// rtl/skiroc_scan_sequencer_scan_next_chip.sv - picks the highest enabled chip below the current select
module scan_next_chip
    import skiroc_scan_sequencer_pkg::*;
(
    input  logic [NUM_CHIPS-1:0] chip_mask,
    input  logic [NUM_CHIPS-1:0] cur_sel,
    output logic [NUM_CHIPS-1:0] next_sel,
    output logic                 none_left
);

    logic [NUM_CHIPS-1:0] below;

    // An all-zero select wraps to all-ones here, so the whole mask is a candidate.
    always_comb begin
        below    = chip_mask & (cur_sel - NUM_CHIPS'(1));
        next_sel = '0;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            if (below[i]) begin
                next_sel    = '0;
                next_sel[i] = 1'b1;
            end
        end
        none_left = (below == '0);
    end

endmodule

// File: rtl/skiroc_scan_sequencer.sv
// rtl/skiroc_scan_sequencer.sv - runs the TA scan on each enabled SKIROC2 chip in turn
// Optional per-chip WAIT_END timeout: define SKIROC_SCAN_TIMEOUT_EN.
module skiroc_scan_sequencer
    import skiroc_scan_sequencer_pkg::*;
#(
    parameter int GAP_CYC     = 16,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                 Clk_10MHz,
    input  logic                 Rst_N,
    input  logic                 In_Start_Scan,
    input  logic                 In_Abort,
    input  logic [NUM_CHIPS-1:0] In_Chip_En,
    input  logic [NUM_CHIPS-1:0] In_Chip_End,
    output logic [NUM_CHIPS-1:0] Out_Chip_Start,
    output logic [NUM_CHIPS-1:0] Out_Chip_Sel,
    output logic                 Out_Busy,
    output logic                 Out_Finish_Scan,
    output logic [NUM_CHIPS-1:0] Out_Err_Flags
);

    scan_state_t          state, state_n;
    logic [NUM_CHIPS-1:0] sel_q, sel_n, mask_q, mask_n;
    logic [NUM_CHIPS-1:0] pick_mask, pick_cur, pick_sel;
    logic                 pick_none;
    logic [7:0]           gap_cnt, gap_n;
    logic                 start_d, start_armed, start_edge;
    logic [NUM_CHIPS-1:0] chip_start_q;
    logic                 busy_q, finish_q;

    // A level still high out of reset must be seen low before it can start a sequence.
    assign start_edge = In_Start_Scan & ~start_d & start_armed;

    assign pick_mask = (state == IDLE) ? In_Chip_En : mask_q;
    assign pick_cur  = (state == IDLE) ? '0 : sel_q;

    scan_next_chip u_next_chip (
        .chip_mask (pick_mask),
        .cur_sel   (pick_cur),
        .next_sel  (pick_sel),
        .none_left (pick_none)
    );

`ifdef SKIROC_SCAN_TIMEOUT_EN
    logic [23:0]          to_cnt, to_n;
    logic [NUM_CHIPS-1:0] err_q, err_n;
`endif

    always_comb begin
        state_n = state;
        sel_n   = sel_q;
        mask_n  = mask_q;
        gap_n   = gap_cnt;
`ifdef SKIROC_SCAN_TIMEOUT_EN
        to_n    = to_cnt;
        err_n   = err_q;
`endif
        case (state)
            IDLE: begin
                if (start_edge) begin
                    mask_n = In_Chip_En;
`ifdef SKIROC_SCAN_TIMEOUT_EN
                    err_n  = '0;
`endif
                    state_n = pick_none ? DONE : START;
                    sel_n   = pick_none ? '0 : pick_sel;
                end
            end
            START: begin
                state_n = WAIT_END;
`ifdef SKIROC_SCAN_TIMEOUT_EN
                to_n    = '0;
`endif
            end
            WAIT_END: begin
                if ((In_Chip_End & sel_q) != '0) begin
                    state_n = GAP;
                    gap_n   = '0;
                end
`ifdef SKIROC_SCAN_TIMEOUT_EN
                else if (to_cnt == 24'(TIMEOUT_CYC - 1)) begin
                    err_n   = err_q | sel_q;
                    state_n = GAP;
                    gap_n   = '0;
                end else begin
                    to_n = to_cnt + 24'd1;
                end
`endif
            end
            GAP: begin
                if (gap_cnt == 8'(GAP_CYC - 1)) begin
                    state_n = pick_none ? DONE : START;
                    sel_n   = pick_none ? '0 : pick_sel;
                end else begin
                    gap_n = gap_cnt + 8'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
                sel_n   = '0;
            end
            default: begin
                state_n = IDLE;
                sel_n   = '0;
            end
        endcase
        // Abort wins over any start edge or end pulse in the same clock; error flags survive it.
        if (In_Abort) begin
            state_n = IDLE;
            sel_n   = '0;
            mask_n  = mask_q;
`ifdef SKIROC_SCAN_TIMEOUT_EN
            err_n   = err_q;
`endif
        end
    end

    always_ff @(posedge Clk_10MHz or negedge Rst_N) begin
        if (!Rst_N) begin
            state        <= IDLE;
            sel_q        <= '0;
            mask_q       <= '0;
            gap_cnt      <= '0;
            start_d      <= 1'b0;
            start_armed  <= 1'b0;
            chip_start_q <= '0;
            busy_q       <= 1'b0;
            finish_q     <= 1'b0;
        end else begin
            state        <= state_n;
            sel_q        <= sel_n;
            mask_q       <= mask_n;
            gap_cnt      <= gap_n;
            start_d      <= In_Start_Scan;
            start_armed  <= start_armed | ~In_Start_Scan;
            chip_start_q <= (state_n == START) ? sel_n : '0;
            busy_q       <= (state_n == START) || (state_n == WAIT_END) || (state_n == GAP);
            finish_q     <= (state_n == DONE);
        end
    end

`ifdef SKIROC_SCAN_TIMEOUT_EN
    always_ff @(posedge Clk_10MHz or negedge Rst_N) begin
        if (!Rst_N) begin
            to_cnt <= '0;
            err_q  <= '0;
        end else begin
            to_cnt <= to_n;
            err_q  <= err_n;
        end
    end

    assign Out_Err_Flags = err_q;
`else
    assign Out_Err_Flags = '0;
`endif

    assign Out_Chip_Start  = chip_start_q;
    assign Out_Chip_Sel    = sel_q;
    assign Out_Busy        = busy_q;
    assign Out_Finish_Scan = finish_q;

endmodule

// File: tb/tb_skiroc_scan_sequencer.sv
// tb/tb_skiroc_scan_sequencer.sv - directed self-checking bench for skiroc_scan_sequencer
module tb_skiroc_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] chip_en = 4'b0000;
    logic [3:0] inj_end = 4'b0000;
    logic [3:0] resp_end = 4'b0000;
    wire  [3:0] chip_end = inj_end | resp_end;
    logic [3:0] chip_start, chip_sel, err;
    logic       busy, finish;

    int         cyc = 0;
    int         pend_cyc = -1;
    logic [3:0] pend_sel = 4'b0000;
    logic [3:0] resp_mask = 4'b0000;
    int         st_cyc[$];
    int         st_val[$];
    int         fin_cyc[$];
    bit         busy_seen = 1'b0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         t0, t1, t2;

    skiroc_scan_sequencer #(.GAP_CYC(16), .TIMEOUT_CYC(50)) dut (
        .Clk_10MHz       (clk),
        .Rst_N           (rst_n),
        .In_Start_Scan   (start),
        .In_Abort        (abort),
        .In_Chip_En      (chip_en),
        .In_Chip_End     (chip_end),
        .Out_Chip_Start  (chip_start),
        .Out_Chip_Sel    (chip_sel),
        .Out_Busy        (busy),
        .Out_Finish_Scan (finish),
        .Out_Err_Flags   (err)
    );

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor plus engine model: an enabled engine ends 100 clocks after its start.
    always @(negedge clk) begin
        if (chip_start != 4'b0000) begin
            st_cyc.push_back(cyc);
            st_val.push_back(int'(chip_start));
        end
        if (finish) fin_cyc.push_back(cyc);
        if (busy) busy_seen = 1'b1;
        resp_end = (cyc == pend_cyc) ? pend_sel : 4'b0000;
        if (!rst_n) pend_cyc = -1;
        else if ((chip_start & resp_mask) != 4'b0000) begin
            pend_cyc = cyc + 100;
            pend_sel = chip_start;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int st_at(input int i);
        return (i < st_cyc.size()) ? st_cyc[i] : -1;
    endfunction

    function automatic int val_at(input int i);
        return (i < st_val.size()) ? st_val[i] : -1;
    endfunction

    function automatic int fin_at(input int i);
        return (i < fin_cyc.size()) ? fin_cyc[i] : -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        st_cyc.delete();
        st_val.delete();
        fin_cyc.delete();
        busy_seen = 1'b0;
    endtask

    task automatic pulse_start(output int k);
        @(negedge clk);
        start = 1'b1;
        k = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_finish(input string tag, input int bound);
        for (int i = 0; i < bound && fin_cyc.size() == 0; i++) @(negedge clk);
        tick(2);
        check({tag, "_finish_count"}, fin_cyc.size(), 1);
    endtask

    initial begin
        tick(3);
        check("rst_start", int'(chip_start), 0);
        check("rst_sel", int'(chip_sel), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_finish", int'(finish), 0);
        check("rst_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);

        // All four chips, 117-clock spacing.
        chip_en = 4'b1111;
        resp_mask = 4'b1111;
        clear_mon();
        pulse_start(t0);
        tick(105);
        check("all_gap_sel", int'(chip_sel), 8);
        check("all_gap_busy", int'(busy), 1);
        wait_finish("all", 700);
        check("all_nstart", st_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("all_start_val", val_at(i), 8 >> i);
            check("all_start_cyc", st_at(i), t0 + 1 + 117 * i);
        end
        check("all_fin_cyc", fin_at(0), t0 + 469);
        check("all_busy_after", int'(busy), 0);

        // Sparse mask; stray ends, START-time end, mask change and restart attempt ignored.
        chip_en = 4'b0101;
        resp_mask = 4'b0101;
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        inj_end = 4'b0100;
        @(negedge clk);
        inj_end = 4'b0000;
        chip_en = 4'b1111;
        tick(28);
        inj_end = 4'b1000;
        tick(1);
        inj_end = 4'b0000;
        tick(19);
        start = 1'b1;
        check("sparse_sel_mid", int'(chip_sel), 4);
        tick(1);
        start = 1'b0;
        wait_finish("sparse", 600);
        check("sparse_nstart", st_cyc.size(), 2);
        check("sparse_val0", val_at(0), 4);
        check("sparse_cyc0", st_at(0), t0 + 1);
        check("sparse_val1", val_at(1), 1);
        check("sparse_cyc1", st_at(1), t0 + 118);
        check("sparse_fin_cyc", fin_at(0), t0 + 235);

        // Empty mask.
        chip_en = 4'b0000;
        clear_mon();
        pulse_start(t0);
        tick(5);
        check("empty_finish_count", fin_cyc.size(), 1);
        check("empty_fin_cyc", fin_at(0), t0 + 1);
        check("empty_nstart", st_cyc.size(), 0);
        check("empty_busy_seen", int'(busy_seen), 0);

        // Abort while chip 3 waits; then restart from chip 1.
        chip_en = 4'b1111;
        resp_mask = 4'b1101;
        clear_mon();
        pulse_start(t0);
        tick(258);
        check("abort_pre_sel", int'(chip_sel), 2);
        tick(1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_sel", int'(chip_sel), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_start", int'(chip_start), 0);
        tick(20);
        check("abort_no_finish", fin_cyc.size(), 0);
        check("abort_nstart", st_cyc.size(), 3);
        resp_mask = 4'b1111;
        clear_mon();
        pulse_start(t1);
        wait_finish("restart", 700);
        check("restart_val0", val_at(0), 8);
        check("restart_cyc0", st_at(0), t1 + 1);
        check("restart_fin_cyc", fin_at(0), t1 + 469);

        // Reset in GAP with start held high.
        chip_en = 4'b1100;
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        tick(105);
        check("rstmid_pre_sel", int'(chip_sel), 8);
        #10 rst_n = 1'b0;
        #1;
        check("rstmid_sel", int'(chip_sel), 0);
        check("rstmid_start", int'(chip_start), 0);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_finish", int'(finish), 0);
        check("rstmid_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        tick(30);
        check("rstmid_held_nstart", st_cyc.size(), 0);
        check("rstmid_held_busy", int'(busy_seen), 0);
        start = 1'b0;
        tick(1);
        start = 1'b1;
        t2 = cyc;
        tick(1);
        start = 1'b0;
        wait_finish("rearm", 400);
        check("rearm_val0", val_at(0), 8);
        check("rearm_cyc0", st_at(0), t2 + 1);
        check("rearm_nstart", st_cyc.size(), 2);
        check("rearm_fin_cyc", fin_at(0), t2 + 235);

`ifdef SKIROC_SCAN_TIMEOUT_EN
        chip_en = 4'b1100;
        resp_mask = 4'b0100;
        clear_mon();
        pulse_start(t0);
        wait_finish("tmo", 400);
        check("tmo_err", int'(err), 8);
        check("tmo_cyc1", st_at(1), t0 + 68);
        check("tmo_fin_cyc", fin_at(0), t0 + 185);
`else
        check("noto_err", int'(err), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/skiroc_scan_sequencer.md
# skiroc_scan_sequencer

Sequences the automatic threshold (TA) scan across the four SKIROC2 per-chip scan engines on one DIF. Today only chip 1's engine is started. This block starts each enabled engine in turn, waits for its end pulse, and inserts a settling gap between chips. It drives the one-hot chip select that steers Set_SC / FIFO traffic, and reports a single finish pulse plus per-chip timeout errors. It sits between the slow-control command decoder (start, enable mask, abort) and the four scan-engine instances in the auto-scan wrapper.

## Interface
Parameters:
- GAP_CYC, 16: idle clocks between one chip's end and the next chip's start (1..255).
- TIMEOUT_CYC, 10_000_000: maximum clocks in WAIT_END per chip (1 s at 10 MHz); 24-bit.

Ports:
- Clk_10MHz  in  1  system clock; one clock domain only.
- Rst_N  in  1  asynchronous, active-low reset.
- In_Start_Scan  in  1  level; a rising edge starts a sequence.
- In_Abort  in  1  synchronous abort, level-sensitive.
- In_Chip_En  in  4  enable mask; bit 4 = chip 1, bit 1 = chip 4.
- In_Chip_End  in  4  per-engine end pulses, same bit order.
- Out_Chip_Start  out  4  one-clock start pulse to the selected engine.
- Out_Chip_Sel  out  4  one-hot select of the active chip (4'b1000 = chip 1); 0 when idle.
- Out_Busy  out  1  high from START through GAP.
- Out_Finish_Scan  out  1  one-clock pulse at sequence completion.
- Out_Err_Flags  out  4  sticky timeout flags per chip.

## Operation
- States: IDLE, START, WAIT_END, GAP, DONE.
- IDLE: a rising edge on In_Start_Scan does the following.
  - Latches In_Chip_En into the mask register and clears Out_Err_Flags.
  - Selects the highest-order enabled bit (chip 1 first) and goes to START.
  - With an all-zero mask it goes to DONE.
- START: lasts exactly one clock. Out_Chip_Start equals Out_Chip_Sel. Next state is WAIT_END.
- WAIT_END: samples only the In_Chip_End bit of the selected chip.
  - When that bit is high, go to GAP.
  - End bits of unselected chips are ignored.
  - An end pulse arriving during START is ignored.
- GAP: counts GAP_CYC clocks.
  - Then selects the next lower enabled chip and goes to START.
  - If no enabled chip remains, goes to DONE.
- DONE: lasts one clock. Out_Finish_Scan = 1, Out_Chip_Sel = 0, next state IDLE.
- Start edges in any state other than IDLE are ignored; edge detection still tracks the level.
- The latched mask is not affected by In_Chip_En changes mid-sequence.
- In_Abort high in any state forces IDLE on the next clock.
  - All outputs go to their reset values, except Out_Err_Flags, which is kept.
  - No finish pulse is generated.
  - Abort has priority over a simultaneous start edge or end pulse.
- Reset values: Out_Chip_Start = 0, Out_Chip_Sel = 0, Out_Busy = 0, Out_Finish_Scan = 0, Out_Err_Flags = 0. State is IDLE and the start-edge register is 0.
- Reset asserted mid-sequence aborts immediately (asynchronously). After release the block is in IDLE, and a start level that is still high does not count as an edge until it is seen low first.

## Timing
- All outputs are registered.
- Start edge sampled at clock k (high at k, low at k-1): Out_Chip_Start and Out_Busy are high from clock k+1.
- End pulse sampled at clock m in WAIT_END: the GAP count starts at m+1, and the next Out_Chip_Start appears at m+1+GAP_CYC.
- Last chip's end at clock m: Out_Finish_Scan pulses at m+1+GAP_CYC and Out_Busy falls in the same clock.
- All-zero mask: Out_Finish_Scan pulses at k+1; Out_Busy never rises.
- Out_Chip_Sel is stable from START through GAP for the current chip and changes only on entry to the next START.

## Configuration
- SKIROC_SCAN_TIMEOUT_EN defined: a 24-bit counter runs in WAIT_END.
  - When it reaches TIMEOUT_CYC-1 with no end pulse, the selected chip's Out_Err_Flags bit is set and the state moves to GAP, so the sequence continues.
  - An end pulse in the same clock as timeout counts as an end, with no error.
- Not defined: WAIT_END waits indefinitely, Out_Err_Flags is tied to 0, and no counter logic is generated.

## Structure
- Shared package holds:
  - the state enumeration (IDLE, START, WAIT_END, GAP, DONE);
  - NUM_CHIPS = 4;
  - the chip-select one-hot constants (CHIP1_SEL = 4'b1000 … CHIP4_SEL = 4'b0001);
  - the default TIMEOUT_CYC.
- One sub-module: scan_next_chip, a combinational priority picker. It returns the highest enabled bit below the current select, or a none-left flag.

## Test plan
- Mask 4'b1111, each engine ends 100 clocks after its start, GAP_CYC = 16 → four start pulses in order 1000, 0100, 0010, 0001, spaced 117 clocks apart; one Out_Finish_Scan 17 clocks after the last end.
- Mask 4'b0101 → only chips 2 and 4 are started. An end pulse on bit 4 (chip 1) during chip 2's WAIT_END is ignored.
- Mask 4'b0000 → Out_Finish_Scan at k+1; no Out_Chip_Start and no Out_Busy.
- In_Abort during chip 3's WAIT_END → IDLE the next clock, Out_Chip_Sel = 0, no finish pulse. A new start edge then restarts from chip 1.
- With SKIROC_SCAN_TIMEOUT_EN and TIMEOUT_CYC = 50, mask 4'b1100, chip 1 never ends → Out_Err_Flags = 4'b1000 after 50 clocks; chip 2 runs normally; finish pulse asserted.
- Rst_N low mid-GAP while In_Start_Scan is held high → all outputs 0. After release, no restart until In_Start_Scan goes low and then high again.
